// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit and its decoder.
package rv32_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ITYPE_W = 4;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned SEL_W   = 2;

  // Instruction classes produced by the decoder.
  typedef enum logic [ITYPE_W-1:0] {
    IT_OP      = 4'd0,
    IT_OPIMM   = 4'd1,
    IT_BRANCH  = 4'd2,
    IT_LUI     = 4'd3,
    IT_AUIPC   = 4'd4,
    IT_JAL     = 4'd5,
    IT_JALR    = 4'd6,
    IT_LOAD    = 4'd7,
    IT_STORE   = 4'd8,
    IT_ILLEGAL = 4'd15
  } itype_e;

  // Sequencer states; codes 6 and 7 are unused.
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Next-PC source.
  typedef enum logic [SEL_W-1:0] {
    PCSEL_PC4  = 2'd0,
    PCSEL_IMM  = 2'd1,
    PCSEL_JALR = 2'd2,
    PCSEL_TRAP = 2'd3
  } pcsel_e;

  // Register-file write-back source.
  typedef enum logic [SEL_W-1:0] {
    WBSEL_ALU  = 2'd0,
    WBSEL_LOAD = 2'd1,
    WBSEL_PC4  = 2'd2,
    WBSEL_IMM  = 2'd3
  } wbsel_e;

  // ALU operand B source.
  typedef enum logic [SEL_W-1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } srcb_e;

  // Control bundle driven to the datapath.
  typedef struct packed {
    logic   imem_req;
    logic   ir_we;
    logic   dmem_req;
    logic   dmem_we;
    logic   alu_srcA_sel;
    srcb_e  alu_srcB_sel;
    logic   pc_we;
    pcsel_e pc_sel;
    logic   rf_we;
    wbsel_e wb_sel;
    logic   trap;
  } ctrl_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational map from sequencer state and latched instruction class to datapath controls.
module ctrl_output_decode
  import rv32_ctrl_pkg::*;
(
  input  state_e i_state,
  input  itype_e i_itype,
  input  logic   i_werf,
  input  logic   i_br_taken,
  input  logic   i_imem_ready,
  input  logic   i_dmem_ready,
  output ctrl_t  o_ctrl
);

  // Moore decode; only ir_we and the store-completion PC update look at ready.
  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      ST_FETCH: begin
        o_ctrl.imem_req = 1'b1;
        o_ctrl.ir_we    = i_imem_ready;
      end
      ST_EXEC: begin
        case (i_itype)
          IT_OPIMM: o_ctrl.alu_srcB_sel = SRCB_IMM;
          IT_AUIPC: begin
            o_ctrl.alu_srcA_sel = 1'b1;
            o_ctrl.alu_srcB_sel = SRCB_IMM;
          end
          IT_BRANCH: begin
            o_ctrl.pc_we  = 1'b1;
            o_ctrl.pc_sel = i_br_taken ? PCSEL_IMM : PCSEL_PC4;
          end
          IT_JAL: begin
            o_ctrl.pc_we  = 1'b1;
            o_ctrl.pc_sel = PCSEL_IMM;
          end
          IT_JALR: begin
            o_ctrl.pc_we  = 1'b1;
            o_ctrl.pc_sel = PCSEL_JALR;
          end
          IT_LOAD, IT_STORE: o_ctrl.alu_srcB_sel = SRCB_IMM;
          default: ;
        endcase
      end
      ST_MEM: begin
        o_ctrl.dmem_req = 1'b1;
        o_ctrl.dmem_we  = (i_itype == IT_STORE);
        if ((i_itype == IT_STORE) && i_dmem_ready) begin
          o_ctrl.pc_we  = 1'b1;
          o_ctrl.pc_sel = PCSEL_PC4;
        end
      end
      ST_WB: begin
        o_ctrl.rf_we = i_werf;
        o_ctrl.pc_we = 1'b1;
        case (i_itype)
          IT_LOAD:          o_ctrl.wb_sel = WBSEL_LOAD;
          IT_LUI:           o_ctrl.wb_sel = WBSEL_IMM;
          IT_JAL, IT_JALR: begin
            o_ctrl.wb_sel = WBSEL_PC4;
            o_ctrl.pc_we  = 1'b0;
          end
          default:          o_ctrl.wb_sel = WBSEL_ALU;
        endcase
      end
      ST_TRAP: begin
        o_ctrl.trap   = 1'b1;
        o_ctrl.pc_we  = 1'b1;
        o_ctrl.pc_sel = PCSEL_TRAP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// RV32I multicycle sequencer: state machine, latched instruction class and retire counter.
module multicycle_control_unit
  import rv32_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ITYPE_W-1:0] iType_in,
  input  logic               werf_in,
  input  logic               br_taken_in,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               ir_we,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               alu_srcA_sel,
  output logic [SEL_W-1:0]   alu_srcB_sel,
  output logic               pc_we,
  output logic [SEL_W-1:0]   pc_sel,
  output logic               rf_we,
  output logic [SEL_W-1:0]   wb_sel,
  output logic               trap,
  output logic [XLEN-1:0]    instret,
  output logic [STATE_W-1:0] state_dbg
);

  state_e          r_state;
  state_e          w_next_state;
  itype_e          r_itype;
  itype_e          w_itype_in;
  logic            w_retire;
  logic [XLEN-1:0] r_instret;
  ctrl_t           w_ctrl;
  ctrl_t           w_ctrl_out;

  // The PC register lives in the datapath; these values only document its reload targets.
  logic w_unused_pc_params;
  assign w_unused_pc_params = ^{RESET_PC, TRAP_PC};

  assign w_itype_in = itype_e'(iType_in);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  // Next-state and retire decision.
  always_comb begin
    w_next_state = ST_FETCH;
    w_retire     = 1'b0;
    unique case (r_state)
      ST_FETCH:  w_next_state = imem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: w_next_state = (w_itype_in == IT_ILLEGAL) ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (r_itype)
          IT_BRANCH: begin
            w_next_state = ST_FETCH;
            w_retire     = 1'b1;
          end
          IT_LOAD, IT_STORE: w_next_state = ST_MEM;
          default:           w_next_state = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (!dmem_ready) begin
          w_next_state = ST_MEM;
        end else if (r_itype == IT_STORE) begin
          w_next_state = ST_FETCH;
          w_retire     = 1'b1;
        end else begin
          w_next_state = ST_WB;
        end
      end
      ST_WB: begin
        w_next_state = ST_FETCH;
        w_retire     = 1'b1;
      end
      ST_TRAP: w_next_state = ST_FETCH;
      default: w_next_state = ST_FETCH;
    endcase
  end

  // Instruction class latched while the decoder output is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_itype <= IT_OP;
    else if (r_state == ST_DECODE) r_itype <= w_itype_in;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + XLEN'(1);
  end

  ctrl_output_decode u_decode (
    .i_state      (r_state),
    .i_itype      (r_itype),
    .i_werf       (werf_in),
    .i_br_taken   (br_taken_in),
    .i_imem_ready (imem_ready),
    .i_dmem_ready (dmem_ready),
    .o_ctrl       (w_ctrl)
  );

  // Reset forces every control low at once, aborting any open handshake.
  always_comb begin
    w_ctrl_out = w_ctrl;
    if (reset) w_ctrl_out = '0;
  end

  assign imem_req     = w_ctrl_out.imem_req;
  assign ir_we        = w_ctrl_out.ir_we;
  assign dmem_req     = w_ctrl_out.dmem_req;
  assign dmem_we      = w_ctrl_out.dmem_we;
  assign alu_srcA_sel = w_ctrl_out.alu_srcA_sel;
  assign alu_srcB_sel = w_ctrl_out.alu_srcB_sel;
  assign pc_we        = w_ctrl_out.pc_we;
  assign pc_sel       = w_ctrl_out.pc_sel;
  assign rf_we        = w_ctrl_out.rf_we;
  assign wb_sel       = w_ctrl_out.wb_sel;
  assign trap         = w_ctrl_out.trap;
  assign instret      = r_instret;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-by-cycle directed vectors for the multicycle control unit.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  iType_in;
  logic        werf_in, br_taken_in, imem_ready, dmem_ready;
  logic        imem_req, ir_we, dmem_req, dmem_we, alu_srcA_sel, pc_we, rf_we, trap;
  logic [1:0]  alu_srcB_sel, pc_sel, wb_sel;
  logic [31:0] instret;
  logic [2:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .iType_in     (iType_in),
    .werf_in      (werf_in),
    .br_taken_in  (br_taken_in),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .alu_srcA_sel (alu_srcA_sel),
    .alu_srcB_sel (alu_srcB_sel),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .trap         (trap),
    .instret      (instret),
    .state_dbg    (state_dbg)
  );

  // One cycle: inputs held for that cycle, outputs expected in it.
  typedef struct {
    logic [3:0]  it;
    logic        werf, br, ir, dr;
    logic [2:0]  st;
    logic [13:0] ctl;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];

  // Field order: ireq irwe dreq dwe srcA srcB pcwe pcsel rfwe wbsel trap.
  function automatic logic [13:0] act_ctl();
    return {imem_req, ir_we, dmem_req, dmem_we, alu_srcA_sel, alu_srcB_sel,
            pc_we, pc_sel, rf_we, wb_sel, trap};
  endfunction

  task automatic add(input int it, input int w, input int br, input int ir, input int dr,
                     input int st, input int ireq, input int irwe, input int dreq, input int dwe,
                     input int sa, input int sb, input int pcwe, input int pcs, input int rfwe,
                     input int wbs, input int trp, input int ret);
    vec_t v;
    v.it   = 4'(it);
    v.werf = 1'(w);
    v.br   = 1'(br);
    v.ir   = 1'(ir);
    v.dr   = 1'(dr);
    v.st   = 3'(st);
    v.ctl  = {1'(ireq), 1'(irwe), 1'(dreq), 1'(dwe), 1'(sa), 2'(sb),
              1'(pcwe), 2'(pcs), 1'(rfwe), 2'(wbs), 1'(trp)};
    v.ret  = 32'(ret);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] it, input logic w, input logic br,
                       input logic ir, input logic dr);
    iType_in    = it;
    werf_in     = w;
    br_taken_in = br;
    imem_ready  = ir;
    dmem_ready  = dr;
  endtask

  initial begin
    //  it w br ir dr st  ireq irwe dreq dwe sa sb pcwe pcs rfwe wbs trp ret
    // addi, imem_ready late by 3 cycles
    add(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 2,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    // lw, dmem_ready after 2 cycles
    add(7, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(7, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(7, 1, 0, 0, 0, 2,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(7, 1, 0, 0, 0, 3,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(7, 1, 0, 0, 0, 3,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(7, 1, 0, 0, 1, 3,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(7, 1, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1);
    // sw, dmem_ready immediate
    add(8, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(8, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(8, 0, 0, 0, 0, 2,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2);
    add(8, 0, 0, 0, 1, 3,  0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 2);
    // beq taken
    add(2, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add(2, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add(2, 0, 1, 0, 0, 2,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3);
    // bne not taken
    add(2, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    add(2, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    add(2, 0, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4);
    // jal
    add(5, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    add(5, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    add(5, 1, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 5);
    add(5, 1, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 5);
    // jalr
    add(6, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    add(6, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    add(6, 1, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 6);
    add(6, 1, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 6);
    // illegal
    add(15, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    add(15, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    add(15, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 7);
    // lui (also shows instret unchanged by the trap)
    add(3, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    add(3, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    add(3, 1, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    add(3, 1, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 0, 7);
    // auipc, stray readies in WB ignored
    add(4, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    add(4, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    add(4, 1, 0, 0, 0, 2,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 8);
    add(4, 1, 0, 1, 1, 4,  0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 8);
    add(4, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);

    // Reset state
    drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    check("reset_ctl", 32'(act_ctl()), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_instret", instret, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].it, vecs[i].werf, vecs[i].br, vecs[i].ir, vecs[i].dr);
      #1;
      check($sformatf("row%0d_ctl", i), 32'(act_ctl()), 32'(vecs[i].ctl));
      check($sformatf("row%0d_state", i), 32'(state_dbg), 32'(vecs[i].st));
      check($sformatf("row%0d_instret", i), instret, vecs[i].ret);
      @(negedge clk);
    end

    // Reset asserted in the middle of a load's MEM wait
    drive(4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midmem_dreq", 32'(dmem_req), 32'd1);
    check("midmem_state", 32'(state_dbg), 32'd3);
    #1;
    reset      = 1'b1;
    dmem_ready = 1'b1;
    #1;
    check("rst_async_ctl", 32'(act_ctl()), 32'd0);
    check("rst_async_state", 32'(state_dbg), 32'd0);
    check("rst_async_instret", instret, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("post_rst_ireq", 32'(act_ctl()), 32'h2000);
    check("post_rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    check("post_rst_decode", 32'(state_dbg), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("post_rst_wb", 32'(state_dbg), 32'd4);
    @(negedge clk);
    #1;
    check("post_rst_instret", instret, 32'd1);
    check("post_rst_fetch", 32'(state_dbg), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
